// File: rtl/signed_alu_sequencer.sv
// rtl/signed_alu_sequencer.sv - multi-cycle request/response sequencer for a combinational signed ALU
//
// Purpose:
//   Accepts one operation at a time, registers the operands/opcode that drive an
//   external combinational arithmetic unit, waits a per-opcode settle latency,
//   then captures the unit's answer and holds it on the response channel until
//   it is taken. Divide-by-zero is answered directly without waiting on the divider.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   in_valid/in_ready          request handshake
//   in_a, in_b, in_op          request operands and opcode (00 add, 01 sub, 10 mul, 11 div)
//   alu_a, alu_b, alu_op       registered operands/opcode to the arithmetic unit
//   alu_answer                 arithmetic unit result
//   out_valid/out_ready        response handshake
//   out_data, out_div_zero     captured result and divide-by-zero flag
//   busy                       sequencer not idle
//   op_count                   completed-response counter (wraps)

`timescale 1ns/1ps

module signed_alu_sequencer #(
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned SUB_LAT = 1,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [1:0]  in_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_answer,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_div_zero,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The wait counter is loaded with LAT-1 so that the capture edge lands
  // exactly LAT edges after the accept edge.
  localparam logic [7:0] L_ADD_M1 = 8'(ADD_LAT - 1);
  localparam logic [7:0] L_SUB_M1 = 8'(SUB_LAT - 1);
  localparam logic [7:0] L_MUL_M1 = 8'(MUL_LAT - 1);
  localparam logic [7:0] L_DIV_M1 = 8'(DIV_LAT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_count;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [1:0]  r_alu_op;
  logic [31:0] r_out_data;
  logic        r_out_div_zero;
  logic [15:0] r_op_count;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_div_zero_req;
  logic        w_wait_done;
  logic        w_handshake;
  logic [7:0]  w_lat_m1;

  assign w_in_ready     = (r_state == S_IDLE) && !reset;
  assign w_accept       = in_valid && w_in_ready;
  assign w_div_zero_req = (in_op == 2'b11) && (in_b == 32'd0);
  assign w_wait_done    = (r_state == S_WAIT) && (r_count == 8'd0);
  assign w_handshake    = (r_state == S_DONE) && out_ready;

  always_comb begin
    w_lat_m1 = L_ADD_M1;
    case (in_op)
      2'b00:   w_lat_m1 = L_ADD_M1;
      2'b01:   w_lat_m1 = L_SUB_M1;
      2'b10:   w_lat_m1 = L_MUL_M1;
      default: w_lat_m1 = L_DIV_M1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // Divide-by-zero skips the wait: the divider output is meaningless.
          w_next_state = w_div_zero_req ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_wait_done) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count        <= 8'd0;
      r_alu_a        <= 32'd0;
      r_alu_b        <= 32'd0;
      r_alu_op       <= 2'b00;
      r_out_data     <= 32'd0;
      r_out_div_zero <= 1'b0;
      r_op_count     <= 16'd0;
    end else begin
      if (w_accept) begin
        r_alu_a  <= in_a;
        r_alu_b  <= in_b;
        r_alu_op <= in_op;
        if (w_div_zero_req) begin
          r_out_data     <= 32'd0;
          r_out_div_zero <= 1'b1;
        end else begin
          r_count <= w_lat_m1;
        end
      end
      if (r_state == S_WAIT) begin
        if (r_count != 8'd0) begin
          r_count <= r_count - 8'd1;
        end else begin
          r_out_data     <= alu_answer;
          r_out_div_zero <= 1'b0;
        end
      end
      if (w_handshake) begin
        r_op_count <= r_op_count + 16'd1;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign busy         = (r_state != S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_op       = r_alu_op;
  assign out_data     = r_out_data;
  assign out_div_zero = r_out_div_zero;
  assign op_count     = r_op_count;

endmodule

// File: tb/tb_signed_alu_sequencer.sv
// tb/tb_signed_alu_sequencer.sv - self-checking bench for signed_alu_sequencer

`timescale 1ns/1ps

module tb_signed_alu_sequencer;

  localparam int ADD_LAT = 1;
  localparam int SUB_LAT = 1;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_op;
  logic [31:0] alu_answer;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_div_zero;
  logic        busy;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  signed_alu_sequencer #(
    .ADD_LAT(ADD_LAT), .SUB_LAT(SUB_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_answer(alu_answer),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_div_zero(out_div_zero),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Arithmetic unit behaviour; a divide by zero yields junk so that the
  // sequencer's own zero answer is distinguishable.
  function automatic logic [31:0] arith(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] r;
    sa = a;
    sb = b;
    case (op)
      2'b00: r = sa + sb;
      2'b01: r = sa - sb;
      2'b10: r = sa * sb;
      default: begin
        if (b == 32'd0) r = 32'hDEADBEEF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = sa;
        else r = sa / sb;
      end
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'b00: return ADD_LAT;
      2'b01: return SUB_LAT;
      2'b10: return MUL_LAT;
      default: return DIV_LAT;
    endcase
  endfunction

  assign alu_answer = arith(alu_a, alu_b, alu_op);

  // Reference model: a pending operation becomes visible at a known cycle index.
  longint      cyc = 0;
  bit          m_known = 0;
  bit          m_pend = 0;
  longint      m_valid_at = 0;
  logic [31:0] m_result = 0;
  logic        m_dz = 0;
  logic [31:0] m_alu_a = 0;
  logic [31:0] m_alu_b = 0;
  logic [1:0]  m_alu_op = 0;
  logic [15:0] m_count = 0;
  int          preload_seq = 0;
  int          preload_seen = 0;

  always @(posedge clk) begin
    if (preload_seq != preload_seen) begin
      preload_seen = preload_seq;
      m_count = 16'hFFFF;
    end
    if (reset) begin
      m_known  = 1;
      m_pend   = 0;
      m_alu_a  = 0;
      m_alu_b  = 0;
      m_alu_op = 0;
      m_count  = 0;
    end else if (m_known) begin
      if (m_pend) begin
        if (cyc >= m_valid_at && out_ready) begin
          m_pend  = 0;
          m_count = m_count + 16'd1;
        end
      end else if (in_valid) begin
        m_pend   = 1;
        m_alu_a  = in_a;
        m_alu_b  = in_b;
        m_alu_op = in_op;
        if (in_op == 2'b11 && in_b == 32'd0) begin
          m_result   = 32'd0;
          m_dz       = 1;
          m_valid_at = cyc + 1;
        end else begin
          m_result   = arith(in_a, in_b, in_op);
          m_dz       = 0;
          m_valid_at = cyc + 1 + lat_of(in_op);
        end
      end
    end
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    bit ev;
    forever begin
      @(negedge clk);
      if (m_known) begin
        ev = m_pend && (cyc >= m_valid_at);
        check("in_ready", in_ready, !m_pend && !reset);
        check("busy", busy, m_pend);
        check("out_valid", out_valid, ev);
        if (ev) begin
          check("out_data", out_data, m_result);
          check("out_div_zero", out_div_zero, m_dz);
        end
        check("alu_a", alu_a, m_alu_a);
        check("alu_b", alu_b, m_alu_b);
        check("alu_op", alu_op, m_alu_op);
        check("op_count", op_count, m_count);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input int hold, input logic [31:0] exp_data, input logic exp_dz,
                        input int exp_lat, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, " ready"}, in_ready, 1);
    in_a = a; in_b = b; in_op = op; in_valid = 1;
    tick();
    in_valid = 0;
    in_a = $urandom; in_b = $urandom; in_op = 2'($urandom);
    n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " data"}, out_data, exp_data);
    check({tag, " div_zero"}, out_div_zero, exp_dz);
    in_valid = (hold > 0);
    repeat (hold) begin
      tick();
      check({tag, " held data"}, out_data, exp_data);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  initial begin
    fork
      compare_loop();
    join_none
    reset = 1;
    repeat (2) tick();
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset op_count", op_count, 0);
    check("reset alu_a", alu_a, 0);
    reset = 0;
    #1;
    check("idle in_ready", in_ready, 1);

    run_op(32'd5, 32'hFFFFFFFD, 2'b00, 0, 32'd2, 1'b0, 1, "add");
    check("add op_count", op_count, 16'd1);
    run_op(32'hFFFFFFF9, 32'd6, 2'b10, 0, 32'hFFFFFFD6, 1'b0, 4, "mul");
    run_op(32'd100, 32'd0, 2'b11, 0, 32'd0, 1'b1, 0, "div0");
    check("div0 alu_op held", alu_op, 2'b11);
    run_op(32'd100, 32'hFFFFFFF9, 2'b11, 0, 32'hFFFFFFF2, 1'b0, 8, "div");
    run_op(32'd10, 32'd20, 2'b01, 5, 32'hFFFFFFF6, 1'b0, 1, "sub");
    check("sub op_count", op_count, 16'd5);

    // Reset while a multiply is waiting.
    in_a = 32'd3; in_b = 32'd9; in_op = 2'b10; in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    #1;
    check("midwait in_ready", in_ready, 1);
    check("midwait out_valid", out_valid, 0);
    check("midwait alu_a", alu_a, 0);
    check("midwait op_count", op_count, 0);
    repeat (10) tick();
    check("midwait no response", out_valid, 0);

    // Randomized traffic with occasional reset.
    repeat (4000) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a      = $urandom;
      in_op     = 2'($urandom);
      in_b      = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    in_valid = 0; out_ready = 0;
    reset = 1;
    tick();
    reset = 0;

    // Counter wrap: preload the completed-op counter to its maximum.
    @(negedge clk);
    #1;
    force dut.r_op_count = 16'hFFFF;
    preload_seq = preload_seq + 1;
    @(posedge clk);
    #1;
    release dut.r_op_count;
    check("wrap preload", op_count, 16'hFFFF);
    run_op(32'd1, 32'd1, 2'b00, 0, 32'd2, 1'b0, 1, "wrap add");
    check("wrap op_count", op_count, 16'h0000);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_alu_sequencer.md
Name: signed_alu_sequencer

Overview:
Multi-cycle controller in front of the combinational signed arithmetic unit (add/sub/mul/div, 2-bit opcode select). Accepts one operation at a time over a valid/ready request channel, registers the operands and opcode that drive the unit, and waits a per-opcode settle latency. It then captures the 32-bit answer and presents it on a valid/ready response channel. Divide-by-zero is intercepted without waiting on the divider.

Parameters:
ADD_LAT, 1, cycles from accept to capture for opcode 00 (1..255)
SUB_LAT, 1, cycles for opcode 01 (1..255)
MUL_LAT, 4, cycles for opcode 10 (1..255)
DIV_LAT, 8, cycles for opcode 11 (1..255)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  sequencer can accept a request
in_a  input  32  operand A, two's complement
in_b  input  32  operand B, two's complement
in_op  input  2  00 add, 01 sub, 10 mul (low 32 bits of product), 11 div (quotient)
alu_a  output  32  registered operand A to arithmetic unit
alu_b  output  32  registered operand B to arithmetic unit
alu_op  output  2  registered opcode to arithmetic unit
alu_answer  input  32  arithmetic unit result
out_valid  output  1  result held and valid
out_ready  input  1  consumer takes result
out_data  output  32  captured result
out_div_zero  output  1  result is from a divide with B==0
busy  output  1  state != IDLE
op_count  output  16  completed-response counter

Behaviour:
- One clock (clk); reset is synchronous and active-high. When reset is sampled high: state=IDLE, counter=0, alu_a/alu_b/out_data=0, alu_op=00, out_valid=0, out_div_zero=0, op_count=0. Reset mid-operation abandons the operation with no response.
- States: IDLE, WAIT, DONE.
- in_ready = (state==IDLE) and not reset. busy = (state!=IDLE). Both are combinational from state.
- IDLE: on in_valid && in_ready at an edge:
  - Latch alu_a=in_a, alu_b=in_b, alu_op=in_op.
  - If in_op==11 and in_b==0: go to DONE. Set out_data=0 and out_div_zero=1 at the same edge, so out_valid is high 1 cycle after accept.
  - Otherwise load counter=LAT(in_op)-1 and go to WAIT.
- WAIT: alu_* stay stable. At each edge, if counter!=0, decrement. If counter==0, capture out_data=alu_answer, set out_div_zero=0, and go to DONE.
- Latency: out_valid rises exactly LAT(op) edges after the accept edge. Example: ADD_LAT=1 gives out_valid high in the cycle after accept.
- DONE: out_valid=1. out_data and out_div_zero are held stable until the handshake.
  - On out_ready at an edge: go to IDLE and increment op_count (16-bit, wraps 0xFFFF->0x0000).
  - out_ready while out_valid=0 is ignored.
- No new request is accepted in the handshake cycle; back-to-back throughput is one op per LAT+2 cycles minimum.
- alu_a/alu_b/alu_op keep their last values in IDLE and DONE; they change only on an accept edge.
- in_* inputs are ignored outside an accept edge, so changes during WAIT have no effect.
- Arithmetic semantics belong to the arithmetic unit. The sequencer passes alu_answer unmodified and does no sign extension or overflow detection.
- LAT parameters of 0 are illegal; behaviour is undefined.

Test Plan:
- Reset then add: in_a=5, in_b=-3 (0xFFFFFFFD), op=00, ADD_LAT=1 -> out_valid 1 cycle after accept, out_data=2, out_div_zero=0, op_count=1 after out_ready.
- Multiply with latency: in_a=-7, in_b=6, op=10, MUL_LAT=4 -> in_ready=0 and busy=1 for 4 cycles, out_data=0xFFFFFFD6 (-42); in_* changes during WAIT do not alter the result.
- Divide by zero: in_a=100, in_b=0, op=11 -> out_valid next cycle, out_data=0, out_div_zero=1, alu_op=11 held. A following div 100/-7 with DIV_LAT=8 -> out_data=-14, out_div_zero=0.
- Backpressure: sub 10-20 with out_ready held low 5 cycles -> out_valid stays 1, out_data=0xFFFFFFF6 stable, in_valid ignored (in_ready=0), op_count unchanged until out_ready.
- Reset mid-WAIT: start mul, assert reset at cycle 2 -> next cycle state=IDLE, in_ready=1, out_valid=0, alu_a=0, op_count=0, no response issued.
- Counter wrap: preload 65535 completed ops (or force) then one more handshake -> op_count=0x0000.
